// File: rtl/frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : frame_writer
// Description : Write-side controller for the double-buffered frame store.
//               Linearises the ray marcher's pixel stream into BRAM writes,
//               stalls the producer at frame end, and requests a buffer swap
//               only once the frame has drained and the display is in
//               vertical blanking (at most one swap per blanking interval).
// Revision    : 1.0 - initial release
// ============================================================================
module frame_writer #(
    parameter int DISPLAY_WIDTH  = 320,
    parameter int DISPLAY_HEIGHT = 240,
    parameter int H_BITS         = $clog2(DISPLAY_WIDTH),
    parameter int V_BITS         = $clog2(DISPLAY_HEIGHT),
    parameter int ADDR_BITS      = H_BITS + V_BITS,
    parameter int COLOR_WIDTH    = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [H_BITS-1:0]      hcount_in,
    input  logic [V_BITS-1:0]      vcount_in,
    input  logic [COLOR_WIDTH-1:0] color_in,
    input  logic                   valid_in,
    input  logic                   new_frame_in,
    output logic                   ready_out,
    input  logic                   vblank_in,
    output logic                   write_enable_out,
    output logic [ADDR_BITS-1:0]   write_addr_out,
    output logic [COLOR_WIDTH-1:0] write_data_out,
    output logic                   swap_buffers_out,
    output logic [7:0]             frame_count_out,
    output logic                   last_frame_full_out,
    output logic [15:0]            dropped_count_out
);

    typedef enum logic [1:0] {
        WRITING     = 2'd0,
        DRAIN       = 2'd1,
        WAIT_VBLANK = 2'd2,
        SWAP        = 2'd3
    } state_t;

    // Limits one bit wider than the coordinate so any parameterisation fits.
    localparam logic [H_BITS:0]      H_LIMIT     = (H_BITS + 1)'(DISPLAY_WIDTH);
    localparam logic [V_BITS:0]      V_LIMIT     = (V_BITS + 1)'(DISPLAY_HEIGHT);
    localparam logic [ADDR_BITS-1:0] LINE_STRIDE = ADDR_BITS'(DISPLAY_WIDTH);
    localparam logic [ADDR_BITS:0]   FULL_COUNT  = (ADDR_BITS + 1)'(DISPLAY_WIDTH * DISPLAY_HEIGHT);
    localparam logic [ADDR_BITS:0]   COUNT_MAX   = {(ADDR_BITS + 1){1'b1}};

    state_t                 state;
    logic                   pix_accept;
    logic                   eof_accept;
    logic                   pix_in_range;

    logic                   s1_valid;
    logic                   s1_in_range;
    logic [H_BITS-1:0]      s1_h;
    logic [V_BITS-1:0]      s1_v;
    logic [COLOR_WIDTH-1:0] s1_color;

    logic                   armed;
    logic [ADDR_BITS:0]     pixel_count;

    assign ready_out    = (state == WRITING) && !rst_in;
    assign pix_accept   = valid_in && ready_out;
    assign eof_accept   = new_frame_in && ready_out;
    assign pix_in_range = ({1'b0, hcount_in} < H_LIMIT) && ({1'b0, vcount_in} < V_LIMIT);

    // Stage 1: capture the accepted pixel and its range classification.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_valid    <= 1'b0;
            s1_in_range <= 1'b0;
            s1_h        <= '0;
            s1_v        <= '0;
            s1_color    <= '0;
        end else begin
            s1_valid    <= pix_accept;
            s1_in_range <= pix_in_range;
            s1_h        <= hcount_in;
            s1_v        <= vcount_in;
            s1_color    <= color_in;
        end
    end

    // Stage 2: issue the BRAM write; address/data hold when nothing is written.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            write_enable_out <= 1'b0;
            write_addr_out   <= '0;
            write_data_out   <= '0;
        end else begin
            write_enable_out <= s1_valid && s1_in_range;
            if (s1_valid && s1_in_range) begin
                write_addr_out <= ADDR_BITS'(s1_v) * LINE_STRIDE + ADDR_BITS'(s1_h);
                write_data_out <= s1_color;
            end
        end
    end

    // Saturating count of accepted pixels that fell outside the display.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dropped_count_out <= 16'd0;
        end else if (s1_valid && !s1_in_range && (dropped_count_out != 16'hFFFF)) begin
            dropped_count_out <= dropped_count_out + 16'd1;
        end
    end

    // Saturating in-range pixel count for the current frame, cleared leaving SWAP.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pixel_count <= '0;
        end else if (state == SWAP) begin
            pixel_count <= '0;
        end else if (pix_accept && pix_in_range && (pixel_count != COUNT_MAX)) begin
            pixel_count <= pixel_count + 1'b1;
        end
    end

    // Armed re-arms on any non-blanking cycle and is consumed by a swap.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            armed <= 1'b1;
        end else if (!vblank_in) begin
            armed <= 1'b1;
        end else if ((state == WAIT_VBLANK) && armed) begin
            armed <= 1'b0;
        end
    end

    // Frame-end sequencing with registered swap request and frame status.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state               <= WRITING;
            swap_buffers_out    <= 1'b0;
            frame_count_out     <= 8'd0;
            last_frame_full_out <= 1'b0;
        end else begin
            swap_buffers_out <= 1'b0;
            case (state)
                WRITING: begin
                    if (eof_accept) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!s1_valid && !write_enable_out) begin
                        state <= WAIT_VBLANK;
                    end
                end
                WAIT_VBLANK: begin
                    if (vblank_in && armed) begin
                        state               <= SWAP;
                        swap_buffers_out    <= 1'b1;
                        frame_count_out     <= frame_count_out + 8'd1;
                        last_frame_full_out <= (pixel_count == FULL_COUNT);
                    end
                end
                SWAP: begin
                    state <= WRITING;
                end
                default: begin
                    state <= WRITING;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_writer
// Description : Self-checking bench for frame_writer (320x240). Stimulus
//               pushes expected writes/swaps into queues; a monitor pops and
//               compares whenever the design presents a write or a swap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_writer;

    localparam int W  = 320;
    localparam int H  = 240;
    localparam int HB = 9;
    localparam int VB = 8;
    localparam int AB = 17;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [HB-1:0] hcount;
    logic [VB-1:0] vcount;
    logic [CW-1:0] color;
    logic          valid;
    logic          new_frame;
    logic          ready;
    logic          vblank;
    logic          write_enable;
    logic [AB-1:0] write_addr;
    logic [CW-1:0] write_data;
    logic          swap_buffers;
    logic [7:0]    frame_count;
    logic          last_frame_full;
    logic [15:0]   dropped_count;

    frame_writer #(
        .DISPLAY_WIDTH (W),
        .DISPLAY_HEIGHT(H),
        .COLOR_WIDTH   (CW)
    ) dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .hcount_in          (hcount),
        .vcount_in          (vcount),
        .color_in           (color),
        .valid_in           (valid),
        .new_frame_in       (new_frame),
        .ready_out          (ready),
        .vblank_in          (vblank),
        .write_enable_out   (write_enable),
        .write_addr_out     (write_addr),
        .write_data_out     (write_data),
        .swap_buffers_out   (swap_buffers),
        .frame_count_out    (frame_count),
        .last_frame_full_out(last_frame_full),
        .dropped_count_out  (dropped_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int edge_n;
    } wr_t;

    wr_t  wq[$];
    bit   sq[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   swap_cnt = 0;
    int   last_swap_edge = -1;
    int   exp_fc = 0;
    int   exp_dropped = 0;
    int   frame_px = 0;
    int   marker_edge = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboards whenever the design presents output.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (write_enable) begin
                chk("write_expected", int'(wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_addr", int'(write_addr), e.addr);
                    chk("wr_data", int'(write_data), e.data);
                    chk("wr_latency", edge_cnt, e.edge_n);
                end
            end
            if (swap_buffers) begin
                swap_cnt++;
                last_swap_edge = edge_cnt;
                chk("swap_after_drain", wq.size(), 0);
                chk("swap_expected", int'(sq.size() != 0), 1);
                if (sq.size() != 0) begin
                    bit full;
                    full   = sq.pop_front();
                    exp_fc = (exp_fc + 1) % 256;
                    chk("frame_count", int'(frame_count), exp_fc);
                    chk("last_frame_full", int'(last_frame_full), int'(full));
                end
            end
        end
    end

    // Present one beat and hold it until accepted; records expectations.
    task automatic drive(input int h, input int v, input int c, input bit pv, input bit nf);
        int guard;
        @(negedge clk);
        hcount    = HB'(h);
        vcount    = VB'(v);
        color     = CW'(c);
        valid     = pv;
        new_frame = nf;
        guard     = 0;
        while (!ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
        if (pv) begin
            if (h < W && v < H) begin
                wq.push_back('{addr: v * W + h, data: c, edge_n: edge_cnt + 2});
                frame_px++;
            end else begin
                exp_dropped++;
            end
        end
        if (nf) begin
            sq.push_back(frame_px == W * H);
            frame_px    = 0;
            marker_edge = edge_cnt + 1;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        valid     = 1'b0;
        new_frame = 1'b0;
    endtask

    task automatic wait_swap(input int base, input int limit);
        int n;
        n = 0;
        while (swap_cnt == base && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int base, t0, hi_cnt, np;
        rst = 1'b1; vblank = 1'b0; valid = 1'b0; new_frame = 1'b0;
        hcount = '0; vcount = '0; color = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(ready), 0);
        chk("rst_we", int'(write_enable), 0);
        chk("rst_addr", int'(write_addr), 0);
        chk("rst_swap", int'(swap_buffers), 0);
        chk("rst_fc", int'(frame_count), 0);
        chk("rst_dropped", int'(dropped_count), 0);
        rst = 1'b0;
        #1 chk("ready_after_release", int'(ready), 1);

        // Single pixel, then two out-of-range pixels
        drive(3, 2, 4'hA, 1'b1, 1'b0);
        idle();
        drive(320, 0, 4'h5, 1'b1, 1'b0);
        drive(0, 240, 4'h6, 1'b1, 1'b0);
        idle();
        repeat (5) @(negedge clk);
        chk("dropped_two", int'(dropped_count), 2);
        chk("no_swap_yet", swap_cnt, 0);

        // Marker with no blanking: held off for 100 cycles, then swap
        drive(0, 0, 0, 1'b0, 1'b1);
        idle();
        hi_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (ready) hi_cnt++;
        end
        chk("ready_held_low", hi_cnt, 0);
        chk("no_swap_without_vblank", swap_cnt, 0);
        vblank = 1'b1;
        t0 = edge_cnt;
        @(negedge clk);
        chk("swap_on_vblank", swap_cnt, 1);
        chk("swap_on_vblank_edge", last_swap_edge, t0 + 1);
        @(negedge clk);

        // Full raster back-to-back, final pixel together with the marker
        vblank = 1'b0;
        @(negedge clk);
        vblank = 1'b1;
        for (int v = 0; v < H; v++) begin
            for (int h = 0; h < W; h++) begin
                bit last;
                last = (v == H - 1) && (h == W - 1);
                drive(h, v, int'($urandom_range(0, 15)), 1'b1, last);
            end
        end
        idle();
        chk("ready_low_after_marker", int'(ready), 0);
        base = swap_cnt;
        wait_swap(base, 20);
        chk("raster_swap_count", swap_cnt, base + 1);
        chk("raster_swap_edge", last_swap_edge, marker_edge + 4);
        chk("ready_low_in_swap", int'(ready), 0);
        @(negedge clk);
        chk("ready_back_after_swap", int'(ready), 1);

        // Two frames inside one 50-cycle blank: only one swap
        vblank = 1'b0;
        repeat (5) @(negedge clk);
        vblank = 1'b1;
        t0   = edge_cnt;
        base = swap_cnt;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++)
                drive(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)),
                      int'($urandom_range(0, 15)), 1'b1, 1'b0);
            drive(0, 0, 0, 1'b0, 1'b1);
            idle();
        end
        while (edge_cnt < t0 + 50) @(negedge clk);
        chk("one_swap_per_blank", swap_cnt, base + 1);
        vblank = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_swap_outside_blank", swap_cnt, base + 1);
        vblank = 1'b1;
        repeat (2) @(negedge clk);
        chk("second_swap_next_blank", swap_cnt, base + 2);

        // Randomized frames with gaps, stray coordinates and blank toggling
        for (int f = 0; f < 4; f++) begin
            np = int'($urandom_range(5, 30));
            for (int i = 0; i < np; i++) begin
                int hh, vv;
                hh = int'($urandom_range(0, W - 1));
                vv = int'($urandom_range(0, H - 1));
                if ($urandom_range(0, 5) == 0) hh = int'($urandom_range(W, 511));
                if ($urandom_range(0, 5) == 0) vv = int'($urandom_range(H, 255));
                vblank = 1'($urandom_range(0, 1));
                drive(hh, vv, int'($urandom_range(0, 15)), 1'b1, 1'b0);
                if ($urandom_range(0, 2) == 0) idle();
            end
            drive(0, 0, 0, 1'b0, 1'b1);
            idle();
            base = swap_cnt;
            vblank = 1'b0;
            repeat (int'($urandom_range(1, 6))) @(negedge clk);
            vblank = 1'b1;
            wait_swap(base, 60);
            chk("random_frame_swap", swap_cnt, base + 1);
            repeat (2) @(negedge clk);
        end
        chk("dropped_random", int'(dropped_count), exp_dropped);

        // Reset during DRAIN with a write in flight
        drive(7, 9, 4'h3, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1; valid = 1'b0; new_frame = 1'b0;
        wq.delete(); sq.delete();
        exp_fc = 0; exp_dropped = 0; frame_px = 0;
        base = swap_cnt;
        #1;
        chk("midrst_we", int'(write_enable), 0);
        chk("midrst_swap", int'(swap_buffers), 0);
        chk("midrst_fc", int'(frame_count), 0);
        chk("midrst_ready", int'(ready), 0);
        chk("midrst_dropped", int'(dropped_count), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_after_midrst", int'(ready), 1);
        repeat (8) @(negedge clk);
        chk("no_swap_after_midrst", swap_cnt, base);
        drive(1, 1, 4'h5, 1'b1, 1'b0);
        idle();
        repeat (4) @(negedge clk);
        chk("queue_empty_end", wq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
